// File: rtl/cpu6_tmr_extirq.sv
// cpu6_tmr_extirq: memory-mapped 64-bit mtime/mtimecmp timer with prescaler and
// a synchronised, optionally edge-latched external interrupt for the cpu6 core.
module cpu6_tmr_extirq #(
   parameter logic [31:0] ADDR_BASE   = 32'h0200_0000,
   parameter int          PRESCALE    = 1,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwriteM,
   input  logic [31:0] dataaddr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        tmr_sel,
   input  logic        csr_mtie_r,
   input  logic        csr_meie_r,
   input  logic        ext_irq_in,
   output logic        tmr_irq_r,
   output logic        ext_irq_r
);
   logic [63:0]            mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
   logic [15:0]            psc_q, psc_d;
   logic [1:0]             ctrl_q, ctrl_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q, pend_q, pend_d, tmr_irq_q, ext_irq_q;
   logic                   we, tick, ext_sync, pend_clr;
   logic [2:0]             off;
   logic                   unused_addr;

   assign tmr_sel     = dataaddr[31:5] == ADDR_BASE[31:5];
   assign we          = memwriteM & tmr_sel;
   assign off         = dataaddr[4:2];
   assign unused_addr = ^dataaddr[1:0];
   assign ext_sync    = sync_q[SYNC_STAGES-1];
   assign tick        = ctrl_q[0] & (psc_q == 16'(PRESCALE - 1));
   assign pend_clr    = we & (off == 3'd5) & writedata[0];
   assign tmr_irq_r   = tmr_irq_q;
   assign ext_irq_r   = ext_irq_q;

   // A software write to either mtime half suppresses that cycle's increment.
   always_comb begin
      psc_d      = ctrl_q[0] ? (tick ? '0 : psc_q + 16'd1) : psc_q;
      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      if (we && off == 3'd0) mtime_d = {mtime_q[63:32], writedata};
      if (we && off == 3'd1) mtime_d = {writedata, mtime_q[31:0]};
      mtimecmp_d = mtimecmp_q;
      if (we && off == 3'd2) mtimecmp_d[31:0] = writedata;
      if (we && off == 3'd3) mtimecmp_d[63:32] = writedata;
      ctrl_d     = (we && off == 3'd4) ? writedata[1:0] : ctrl_q;
      pend_d     = ctrl_q[1] ? ((ext_sync & ~hist_q) | (pend_q & ~pend_clr)) : ext_sync;
   end

   always_comb begin
      readdata = '0;
      case (off)
         3'd0: readdata = mtime_q[31:0];
         3'd1: readdata = mtime_q[63:32];
         3'd2: readdata = mtimecmp_q[31:0];
         3'd3: readdata = mtimecmp_q[63:32];
         3'd4: readdata = {30'd0, ctrl_q};
         3'd5: readdata = {31'd0, pend_q};
         default: readdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         psc_q      <= '0;
         ctrl_q     <= 2'b01;
         sync_q     <= '0;
         hist_q     <= 1'b0;
         pend_q     <= 1'b0;
         tmr_irq_q  <= 1'b0;
         ext_irq_q  <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         psc_q      <= psc_d;
         ctrl_q     <= ctrl_d;
         sync_q     <= {sync_q[SYNC_STAGES-2:0], ext_irq_in};
         hist_q     <= ext_sync;
         pend_q     <= pend_d;
         tmr_irq_q  <= csr_mtie_r & (mtime_q >= mtimecmp_q);
         ext_irq_q  <= csr_meie_r & pend_q;
      end
   end
endmodule

// File: tb/tb_cpu6_tmr_extirq.sv
// tb_cpu6_tmr_extirq: directed and randomized checks of cpu6_tmr_extirq against a
// cycle-level reference built from the register map and interrupt rules.
module tb_cpu6_tmr_extirq;
   localparam logic [31:0] BASE = 32'h0200_0000;
   localparam int P = 4;
   localparam int S = 2;

   logic        clk = 1'b0, reset = 1'b0, memwriteM = 1'b0;
   logic        csr_mtie_r = 1'b0, csr_meie_r = 1'b0, ext_irq_in = 1'b0;
   logic [31:0] dataaddr = BASE, writedata = '0, readdata;
   logic        tmr_sel, tmr_irq_r, ext_irq_r;
   int          n_chk = 0, n_fail = 0;

   logic [63:0] m_time, m_cmp;
   logic        m_en, m_mode, m_pend, m_tirq, m_eirq;
   int unsigned en_cycles;
   logic        hist[$];
   logic        lv[60];

   always #10 clk = ~clk;

   cpu6_tmr_extirq #(.ADDR_BASE(BASE), .PRESCALE(P), .SYNC_STAGES(S)) dut (
      .clk(clk), .reset(reset), .memwriteM(memwriteM), .dataaddr(dataaddr),
      .writedata(writedata), .readdata(readdata), .tmr_sel(tmr_sel),
      .csr_mtie_r(csr_mtie_r), .csr_meie_r(csr_meie_r), .ext_irq_in(ext_irq_in),
      .tmr_irq_r(tmr_irq_r), .ext_irq_r(ext_irq_r)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic void m_reset();
      m_time = '0; m_cmp = '1; m_en = 1'b1; m_mode = 1'b0; m_pend = 1'b0;
      m_tirq = 1'b0; m_eirq = 1'b0; en_cycles = 0;
      hist = {};
      for (int i = 0; i <= S; i++) hist.push_back(1'b0);
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] off);
      case (off)
         3'd0: return m_time[31:0];
         3'd1: return m_time[63:32];
         3'd2: return m_cmp[31:0];
         3'd3: return m_cmp[63:32];
         3'd4: return {30'd0, m_mode, m_en};
         3'd5: return {31'd0, m_pend};
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit m_tick();
      return m_en && (en_cycles % P == P - 1);
   endfunction

   // One clock: check combinational outputs, advance the reference, check registered outputs.
   task automatic cycle();
      logic [63:0] n_time, n_cmp;
      logic        n_en, n_mode, n_pend, n_t, n_e, xin, we, rst, in_win;
      logic [2:0]  off;
      logic [31:0] wd;
      #1;
      in_win = dataaddr[31:5] == BASE[31:5];
      check("tmr_sel", tmr_sel, in_win);
      if (in_win) check("readdata", readdata, m_read(dataaddr[4:2]));
      rst = !reset; xin = ext_irq_in; we = memwriteM && in_win; off = dataaddr[4:2]; wd = writedata;
      n_time = m_time; n_cmp = m_cmp; n_en = m_en; n_mode = m_mode;
      if (we && off == 3'd0) n_time[31:0] = wd;
      else if (we && off == 3'd1) n_time[63:32] = wd;
      else if (m_tick()) n_time = m_time + 64'd1;
      if (we && off == 3'd2) n_cmp[31:0] = wd;
      if (we && off == 3'd3) n_cmp[63:32] = wd;
      if (we && off == 3'd4) {n_mode, n_en} = wd[1:0];
      n_pend = m_mode ? ((hist[S-1] && !hist[S]) || (m_pend && !(we && off == 3'd5 && wd[0]))) : hist[S-1];
      n_t = csr_mtie_r && (m_time >= m_cmp);
      n_e = csr_meie_r && m_pend;
      @(posedge clk);
      if (rst) m_reset();
      else begin
         if (m_en) en_cycles++;
         m_time = n_time; m_cmp = n_cmp; m_en = n_en; m_mode = n_mode;
         m_pend = n_pend; m_tirq = n_t; m_eirq = n_e;
         hist.push_front(xin);
         void'(hist.pop_back());
      end
      #1;
      check("tmr_irq_r", tmr_irq_r, m_tirq);
      check("ext_irq_r", ext_irq_r, m_eirq);
   endtask

   task automatic wr(input logic [2:0] off, input logic [31:0] d);
      dataaddr = BASE | {27'd0, off, 2'b00}; writedata = d; memwriteM = 1'b1;
      cycle();
      memwriteM = 1'b0;
   endtask

   task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string tag);
      dataaddr = BASE | {27'd0, off, 2'b00}; memwriteM = 1'b0;
      #1;
      check(tag, readdata, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      @(posedge clk); #1;
      m_reset();
      cycle();
      reset = 1'b1;
      rd(0, 32'h0, "rst_mtime_lo");
      rd(1, 32'h0, "rst_mtime_hi");
      rd(2, 32'hFFFF_FFFF, "rst_cmp_lo");
      rd(3, 32'hFFFF_FFFF, "rst_cmp_hi");
      rd(4, 32'h1, "rst_ctrl");
      rd(5, 32'h0, "rst_pend");
      check("rst_tmr_irq", tmr_irq_r, 1'b0);
      check("rst_ext_irq", ext_irq_r, 1'b0);

      idle(40);
      rd(0, 32'd10, "mtime_after_40");
      wr(4, 32'h0);
      idle(20);
      rd(0, 32'd10, "mtime_disabled_hold");

      wr(1, 32'h0);
      wr(0, 32'hFFFF_FFFF);
      wr(4, 32'h1);
      for (int i = 0; i < 10 && !m_tick(); i++) cycle();
      cycle();
      rd(1, 32'h1, "carry_hi");
      rd(0, 32'h0, "carry_lo");
      for (int i = 0; i < 10 && !m_tick(); i++) cycle();
      wr(0, 32'd5);
      rd(0, 32'd5, "write_beats_inc");

      wr(3, 32'h0);
      wr(2, 32'd20);
      wr(1, 32'h0);
      wr(0, 32'h0);
      csr_mtie_r = 1'b1;
      for (int i = 0; i < 200 && m_time != 64'd20; i++) cycle();
      rd(0, 32'd20, "mtime_at_20");
      check("tmr_before_rise", tmr_irq_r, 1'b0);
      cycle();
      check("tmr_rise", tmr_irq_r, 1'b1);
      wr(2, 32'd100);
      check("tmr_still_high", tmr_irq_r, 1'b1);
      cycle();
      check("tmr_fall", tmr_irq_r, 1'b0);
      csr_mtie_r = 1'b0;
      wr(2, 32'd20);
      repeat (20) begin
         cycle();
         check("tmr_masked", tmr_irq_r, 1'b0);
      end

      csr_meie_r = 1'b1;
      wr(4, 32'h3);
      ext_irq_in = 1'b1;
      cycle();
      ext_irq_in = 1'b0;
      cycle();
      cycle();
      check("edge_before_rise", ext_irq_r, 1'b0);
      cycle();
      check("edge_rise", ext_irq_r, 1'b1);
      idle(5);
      check("edge_hold", ext_irq_r, 1'b1);
      wr(5, 32'h1);
      check("clear_lag", ext_irq_r, 1'b1);
      cycle();
      check("clear_fall", ext_irq_r, 1'b0);

      ext_irq_in = 1'b1;
      cycle();
      ext_irq_in = 1'b0;
      cycle();
      wr(5, 32'h1);
      rd(5, 32'h1, "set_beats_clear");
      idle(3);
      check("set_beats_clear_irq", ext_irq_r, 1'b1);

      wr(4, 32'h1);
      for (int j = 0; j < 60; j++) begin
         ext_irq_in = 1'($urandom_range(0, 1));
         lv[j] = ext_irq_in;
         cycle();
         if (j >= S + 1) check("level_follow", ext_irq_r, lv[j-(S+1)]);
      end

      for (int k = 0; k < 1500; k++) begin
         reset = ($urandom % 200) != 0;
         memwriteM = ($urandom % 4) == 0;
         dataaddr = (($urandom % 10) == 0) ? BASE + 32'd32 + ($urandom % 32) : BASE + ($urandom % 32);
         writedata = ($urandom % 2) ? $urandom : ($urandom % 64);
         if (($urandom % 8) == 0) csr_mtie_r = ~csr_mtie_r;
         if (($urandom % 8) == 0) csr_meie_r = ~csr_meie_r;
         ext_irq_in = ($urandom % 3) == 0;
         cycle();
      end
      reset = 1'b1; memwriteM = 1'b0;
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
